// File: rtl/ocp_ram_ctrl.sv
// OCP slave controller for an inferred single-port, byte-enabled SRAM.
// Define OCP_RAM_ZERO_INIT_EN to zero-fill the array after every reset before accepting commands.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module ocp_ram_ctrl #(
  parameter int ADDR_BITS  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`ADDR_WIDTH-1:0]  i_MAddr,
  input  logic [2:0]              i_MCmd,
  input  logic [DATA_WIDTH-1:0]   i_MData,
  input  logic [DATA_WIDTH/8-1:0] i_MByteEn,
  output logic                    o_SCmdAccept,
  output logic [DATA_WIDTH-1:0]   o_SData,
  output logic [1:0]              o_SResp
);

  localparam int BEN   = DATA_WIDTH / 8;
  localparam int OFS   = (DATA_WIDTH == 64) ? 3 : 2;
  localparam int DEPTH = 1 << ADDR_BITS;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] RESP_NULL = 2'd0;
  localparam logic [1:0] RESP_DVA  = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd3;

  // Handshake: a command is taken on any rising edge where i_MCmd != IDLE and
  // o_SCmdAccept is high; its single response appears RD_LAT cycles later, in order.
  logic                  run;
  logic                  init_we;
  logic [ADDR_BITS-1:0]  init_idx;

`ifdef OCP_RAM_ZERO_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;
  state_t               state, state_nxt;
  logic [ADDR_BITS-1:0] init_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    init_we   = 1'b0;
    case (state)
      ST_INIT: begin
        init_we = 1'b1;
        if (init_cnt == '1) state_nxt = ST_RUN;
      end
      ST_RUN:  run = 1'b1;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign init_idx = init_cnt;
`else
  assign run      = 1'b1;
  assign init_we  = 1'b0;
  assign init_idx = '0;
`endif

  assign o_SCmdAccept = run;

  logic [ADDR_BITS-1:0] cmd_idx;
  logic                 in_range, cmd_vld, cmd_ok, cmd_err, wr_en, rd_en;
  logic                 unused_addr_lsb;

  assign cmd_idx         = i_MAddr[OFS+ADDR_BITS-1:OFS];
  assign in_range        = (i_MAddr[`ADDR_WIDTH-1:OFS+ADDR_BITS] == '0);
  assign cmd_vld         = run && (i_MCmd != CMD_IDLE);
  assign cmd_ok          = in_range && ((i_MCmd == CMD_WRITE) || (i_MCmd == CMD_READ));
  assign cmd_err         = cmd_vld && !cmd_ok;
  assign wr_en           = cmd_vld && cmd_ok && (i_MCmd == CMD_WRITE);
  assign rd_en           = cmd_vld && cmd_ok && (i_MCmd == CMD_READ);
  assign unused_addr_lsb = ^i_MAddr[OFS-1:0];

  logic                  mem_we;
  logic [ADDR_BITS-1:0]  mem_idx;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BEN-1:0]        mem_ben;

  // Zero-fill owns the write port while it runs; commands cannot be accepted then.
  always_comb begin
    mem_we    = wr_en;
    mem_idx   = cmd_idx;
    mem_wdata = i_MData;
    mem_ben   = i_MByteEn;
    if (init_we) begin
      mem_we    = 1'b1;
      mem_idx   = init_idx;
      mem_wdata = '0;
      mem_ben   = '1;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    for (int k = 0; k < BEN; k++) begin
      if (mem_we && mem_ben[k]) mem[mem_idx][k*8 +: 8] <= mem_wdata[k*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) ram_q <= mem[cmd_idx];
  end

  logic                  last_v, last_e;
  logic [DATA_WIDTH-1:0] out_data;

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        last_v <= 1'b0;
        last_e <= 1'b0;
      end else begin
        last_v <= cmd_vld;
        last_e <= cmd_err;
      end
    end
    assign out_data = ram_q;
  end else begin : g_lat2
    logic                  v1, e1;
    logic [DATA_WIDTH-1:0] dout_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v1     <= 1'b0;
        e1     <= 1'b0;
        last_v <= 1'b0;
        last_e <= 1'b0;
        dout_q <= '0;
      end else begin
        v1     <= cmd_vld;
        e1     <= cmd_err;
        last_v <= v1;
        last_e <= e1;
        dout_q <= ram_q;
      end
    end
    assign out_data = dout_q;
  end

  assign o_SResp = !last_v ? RESP_NULL : (last_e ? RESP_ERR : RESP_DVA);
  assign o_SData = (last_v && !last_e) ? out_data : '0;

endmodule
